// File: rtl/mountaincar_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mountaincar_pkg
// Description : Shared FSM state type, float constants and action encodings
//               for the MountainCar episode controller.
// Revision    : 1.0
// ============================================================================
package mountaincar_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_INIT_OBS = 3'd1,
        ST_WAIT_ACT = 3'd2,
        ST_ISSUE    = 3'd3,
        ST_WAIT_RES = 3'd4,
        ST_EMIT_OBS = 3'd5
    } mc_state_t;

    // IEEE-754 single-precision constants
    localparam logic [31:0] MIN_POS  = 32'hbf99999a;
    localparam logic [31:0] GOAL_POS = 32'h3f000000;
    localparam logic [31:0] ZERO_VEL = 32'h00000000;

    localparam logic [1:0] ACT_LEFT  = 2'd0;
    localparam logic [1:0] ACT_NONE  = 2'd1;
    localparam logic [1:0] ACT_RIGHT = 2'd2;

endpackage
`default_nettype wire

// File: rtl/mountaincar_step_counter.sv
`default_nettype none
// ============================================================================
// Module      : mountaincar_step_counter
// Description : Per-episode step counter, truncation compare and episode count.
// Revision    : 1.0
// ============================================================================
module mountaincar_step_counter
    import mountaincar_pkg::*;
#(
    parameter int MAX_STEPS = 200,
    parameter int STEP_WL   = 16,
    parameter int EP_WL     = 32
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_clr,
    input  logic               i_inc,
    input  logic               i_done,
    input  logic               i_ep_inc,
    output logic [STEP_WL-1:0] o_step_cnt,
    output logic               o_trunc_next,
    output logic [EP_WL-1:0]   o_ep_cnt
);

    logic [STEP_WL-1:0] r_step_cnt;
    logic [EP_WL-1:0]   r_ep_cnt;
    logic [STEP_WL-1:0] w_step_nxt;

    assign w_step_nxt = r_step_cnt + STEP_WL'(1);

    // Termination wins over truncation when both land on the same step
    assign o_trunc_next = ~i_done & (w_step_nxt == STEP_WL'(MAX_STEPS));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_step_cnt <= '0;
            r_ep_cnt   <= '0;
        end else begin
            if (i_clr) begin
                r_step_cnt <= '0;
            end else if (i_inc) begin
                r_step_cnt <= w_step_nxt;
            end
            if (i_ep_inc) begin
                r_ep_cnt <= r_ep_cnt + EP_WL'(1);
            end
        end
    end

    assign o_step_cnt = r_step_cnt;
    assign o_ep_cnt   = r_ep_cnt;

endmodule
`default_nettype wire

// File: rtl/mountaincar_episode_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mountaincar_episode_ctrl
// Description : Episode controller between agent and MountainCar compute block.
//               Optional MC_AUTO_RESTART_EN: restart episodes without IDLE.
// Revision    : 1.0
// ============================================================================
module mountaincar_episode_ctrl
    import mountaincar_pkg::*;
#(
    parameter int VEL_WL    = 32,
    parameter int POS_WL    = 32,
    parameter int ACT_WL    = 2,
    parameter int RWD_WL    = 1,
    parameter int MAX_STEPS = 200,
    parameter int STEP_WL   = 16,
    parameter int EP_WL     = 32
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_start,
    input  logic [POS_WL-1:0]  i_init_pos,
    input  logic               i_act_valid,
    input  logic [ACT_WL-1:0]  i_act,
    output logic               o_act_ready,
    output logic               o_cmp_ena,
    output logic [POS_WL-1:0]  o_cmp_pos,
    output logic [VEL_WL-1:0]  o_cmp_vel,
    output logic [ACT_WL-1:0]  o_cmp_act,
    input  logic               i_cmp_valid,
    input  logic [POS_WL-1:0]  i_cmp_pos,
    input  logic [VEL_WL-1:0]  i_cmp_vel,
    input  logic [RWD_WL-1:0]  i_cmp_rwd,
    input  logic               i_cmp_done,
    output logic               o_obs_valid,
    input  logic               i_obs_ready,
    output logic [POS_WL-1:0]  o_obs_pos,
    output logic [VEL_WL-1:0]  o_obs_vel,
    output logic [RWD_WL-1:0]  o_obs_rwd,
    output logic               o_obs_done,
    output logic               o_obs_trunc,
    output logic [STEP_WL-1:0] o_step_cnt,
    output logic [EP_WL-1:0]   o_ep_cnt
);

    mc_state_t          r_state;
    logic [POS_WL-1:0]  r_pos;
    logic [VEL_WL-1:0]  r_vel;
    logic [ACT_WL-1:0]  r_act;
    logic [RWD_WL-1:0]  r_rwd;
    logic               r_done;
    logic               r_trunc;
    logic               r_obs_valid;
    logic               r_act_ready;
    logic               r_cmp_ena;

    logic               w_start;
    logic               w_capture;
    logic               w_ep_end;
    logic               w_clr;
    logic               w_trunc_next;

    assign w_start   = (r_state == ST_IDLE) & i_start;
    assign w_capture = (r_state == ST_WAIT_RES) & i_cmp_valid;
    assign w_ep_end  = (r_state == ST_EMIT_OBS) & i_obs_ready & (r_done | r_trunc);
`ifdef MC_AUTO_RESTART_EN
    assign w_clr     = w_start | w_ep_end;
`else
    assign w_clr     = w_start;
`endif

    mountaincar_step_counter #(
        .MAX_STEPS (MAX_STEPS),
        .STEP_WL   (STEP_WL),
        .EP_WL     (EP_WL)
    ) u_step_counter (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_clr        (w_clr),
        .i_inc        (w_capture),
        .i_done       (i_cmp_done),
        .i_ep_inc     (w_ep_end),
        .o_step_cnt   (o_step_cnt),
        .o_trunc_next (w_trunc_next),
        .o_ep_cnt     (o_ep_cnt)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= ST_IDLE;
            r_pos       <= '0;
            r_vel       <= '0;
            r_act       <= '0;
            r_rwd       <= '0;
            r_done      <= 1'b0;
            r_trunc     <= 1'b0;
            r_obs_valid <= 1'b0;
            r_act_ready <= 1'b0;
            r_cmp_ena   <= 1'b0;
        end else begin
            r_cmp_ena <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_pos       <= i_init_pos;
                        r_vel       <= VEL_WL'(ZERO_VEL);
                        r_rwd       <= '0;
                        r_done      <= 1'b0;
                        r_trunc     <= 1'b0;
                        r_obs_valid <= 1'b1;
                        r_state     <= ST_INIT_OBS;
                    end
                end
                ST_INIT_OBS: begin
                    if (i_obs_ready) begin
                        r_obs_valid <= 1'b0;
                        r_act_ready <= 1'b1;
                        r_state     <= ST_WAIT_ACT;
                    end
                end
                ST_WAIT_ACT: begin
                    if (i_act_valid) begin
                        r_act       <= i_act;
                        r_act_ready <= 1'b0;
                        r_cmp_ena   <= 1'b1;
                        r_state     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    r_state <= ST_WAIT_RES;
                end
                ST_WAIT_RES: begin
                    // pos/vel feed the compute block until this capture
                    if (i_cmp_valid) begin
                        r_pos       <= i_cmp_pos;
                        r_vel       <= i_cmp_vel;
                        r_rwd       <= i_cmp_rwd;
                        r_done      <= i_cmp_done;
                        r_trunc     <= w_trunc_next;
                        r_obs_valid <= 1'b1;
                        r_state     <= ST_EMIT_OBS;
                    end
                end
                ST_EMIT_OBS: begin
                    if (i_obs_ready) begin
                        if (r_done | r_trunc) begin
`ifdef MC_AUTO_RESTART_EN
                            r_pos       <= i_init_pos;
                            r_vel       <= VEL_WL'(ZERO_VEL);
                            r_rwd       <= '0;
                            r_done      <= 1'b0;
                            r_trunc     <= 1'b0;
                            r_state     <= ST_INIT_OBS;
`else
                            r_obs_valid <= 1'b0;
                            r_state     <= ST_IDLE;
`endif
                        end else begin
                            r_obs_valid <= 1'b0;
                            r_act_ready <= 1'b1;
                            r_state     <= ST_WAIT_ACT;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_act_ready = r_act_ready;
    assign o_cmp_ena   = r_cmp_ena;
    assign o_cmp_pos   = r_pos;
    assign o_cmp_vel   = r_vel;
    assign o_cmp_act   = r_act;
    assign o_obs_valid = r_obs_valid;
    assign o_obs_pos   = r_pos;
    assign o_obs_vel   = r_vel;
    assign o_obs_rwd   = r_rwd;
    assign o_obs_done  = r_done;
    assign o_obs_trunc = r_trunc;

endmodule
`default_nettype wire

// File: tb/tb_mountaincar_episode_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mountaincar_episode_ctrl
// Description : Self-checking bench for mountaincar_episode_ctrl (default build).
// Revision    : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_mountaincar_episode_ctrl;

    localparam int MAX_STEPS = 200;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_start = 1'b0;
    logic [31:0] i_init_pos = '0;
    logic        i_act_valid = 1'b0;
    logic [1:0]  i_act = '0;
    logic        o_act_ready;
    logic        o_cmp_ena;
    logic [31:0] o_cmp_pos;
    logic [31:0] o_cmp_vel;
    logic [1:0]  o_cmp_act;
    logic        i_cmp_valid = 1'b0;
    logic [31:0] i_cmp_pos = '0;
    logic [31:0] i_cmp_vel = '0;
    logic [0:0]  i_cmp_rwd = '0;
    logic        i_cmp_done = 1'b0;
    logic        o_obs_valid;
    logic        i_obs_ready = 1'b0;
    logic [31:0] o_obs_pos;
    logic [31:0] o_obs_vel;
    logic [0:0]  o_obs_rwd;
    logic        o_obs_done;
    logic        o_obs_trunc;
    logic [15:0] o_step_cnt;
    logic [31:0] o_ep_cnt;

    mountaincar_episode_ctrl #(.MAX_STEPS(MAX_STEPS)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_init_pos(i_init_pos),
        .i_act_valid(i_act_valid), .i_act(i_act), .o_act_ready(o_act_ready),
        .o_cmp_ena(o_cmp_ena), .o_cmp_pos(o_cmp_pos), .o_cmp_vel(o_cmp_vel), .o_cmp_act(o_cmp_act),
        .i_cmp_valid(i_cmp_valid), .i_cmp_pos(i_cmp_pos), .i_cmp_vel(i_cmp_vel),
        .i_cmp_rwd(i_cmp_rwd), .i_cmp_done(i_cmp_done),
        .o_obs_valid(o_obs_valid), .i_obs_ready(i_obs_ready), .o_obs_pos(o_obs_pos),
        .o_obs_vel(o_obs_vel), .o_obs_rwd(o_obs_rwd), .o_obs_done(o_obs_done),
        .o_obs_trunc(o_obs_trunc), .o_step_cnt(o_step_cnt), .o_ep_cnt(o_ep_cnt)
    );

    always #5 i_clk = ~i_clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference episode state
    logic [31:0] m_pos;
    logic [31:0] m_vel;
    int          m_step;
    int          m_ep;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] all_outputs();
        return 256'({o_act_ready, o_cmp_ena, o_cmp_pos, o_cmp_vel, o_cmp_act, o_obs_valid,
                     o_obs_pos, o_obs_vel, o_obs_rwd, o_obs_done, o_obs_trunc,
                     o_step_cnt, o_ep_cnt});
    endfunction

    function automatic logic [255:0] obs_view();
        return 256'({o_obs_valid, o_obs_pos, o_obs_vel, o_obs_rwd, o_obs_done,
                     o_obs_trunc, o_step_cnt, o_ep_cnt, o_act_ready});
    endfunction

    task automatic start_ep(input logic [31:0] ip);
        @(negedge i_clk);
        i_start    = 1'b1;
        i_init_pos = ip;
        @(negedge i_clk);
        i_start    = 1'b0;
        i_init_pos = $urandom;
        m_pos  = ip;
        m_vel  = 32'h0;
        m_step = 0;
        check("init_obs", obs_view(),
              256'({1'b1, m_pos, m_vel, 1'b0, 1'b0, 1'b0, 16'd0, 32'(m_ep), 1'b0}));
        i_obs_ready = 1'b1;
        @(negedge i_clk);
        i_obs_ready = 1'b0;
        check("init_handshake", 256'({o_obs_valid, o_act_ready}), 256'({1'b0, 1'b1}));
    endtask

    task automatic do_step(input logic [1:0] act, input int lat, input logic dn,
                           input logic [31:0] rp, input int hold, input logic spur,
                           output logic ended);
        int          t;
        int          ena_cnt;
        logic [31:0] rv;
        logic        rr;
        logic        et;
        logic [255:0] exp_obs;
        t = 0;
        while (!o_act_ready && t < 50) begin
            @(negedge i_clk);
            t++;
        end
        check("act_ready", 256'(o_act_ready), 256'(1'b1));
        i_act_valid = 1'b1;
        i_act       = act;
        @(negedge i_clk);
        i_act_valid = 1'b0;
        i_act       = 2'($urandom);
        ena_cnt     = int'(o_cmp_ena);
        repeat (lat) begin
            @(negedge i_clk);
            ena_cnt += int'(o_cmp_ena);
        end
        check("cmp_operands", 256'({o_cmp_pos, o_cmp_vel, o_cmp_act}), 256'({m_pos, m_vel, act}));
        rv = $urandom;
        rr = 1'($urandom);
        i_cmp_valid = 1'b1;
        i_cmp_pos   = rp;
        i_cmp_vel   = rv;
        i_cmp_rwd   = rr;
        i_cmp_done  = dn;
        @(negedge i_clk);
        i_cmp_valid = 1'b0;
        i_cmp_done  = 1'b0;
        m_step++;
        et = !dn && (m_step == MAX_STEPS);
        check("cmp_ena_pulses", 256'(ena_cnt), 256'(1));
        exp_obs = 256'({1'b1, rp, rv, rr, dn, et, 16'(m_step), 32'(m_ep), 1'b0});
        check("step_obs", obs_view(), exp_obs);
        for (int k = 0; k < hold; k++) begin
            i_cmp_valid = spur;
            i_cmp_pos   = $urandom;
            i_cmp_vel   = $urandom;
            i_cmp_done  = 1'($urandom);
            @(negedge i_clk);
        end
        i_cmp_valid = 1'b0;
        i_cmp_done  = 1'b0;
        if (hold > 0) check("obs_hold", obs_view(), exp_obs);
        i_obs_ready = 1'b1;
        @(negedge i_clk);
        i_obs_ready = 1'b0;
        ended = dn || et;
        if (ended) m_ep++;
        m_pos = rp;
        m_vel = rv;
        check("obs_handshake", 256'({o_obs_valid, o_act_ready, o_ep_cnt}),
              256'({1'b0, !ended, 32'(m_ep)}));
    endtask

    initial begin
        logic ended;
        int   k;
        m_ep = 0;

        // Reset state
        repeat (2) @(negedge i_clk);
        check("reset_outputs", all_outputs(), 256'(0));
        i_rst_n = 1'b1;
        @(negedge i_clk);
        check("idle_after_reset", all_outputs(), 256'(0));

        // Episode 1: directed first step, then run to truncation
        start_ep(32'hbf000000);
        // i_start outside IDLE must not reload the position
        i_start = 1'b1; i_init_pos = 32'h12345678;
        @(negedge i_clk);
        i_start = 1'b0;
        check("start_ignored", 256'({o_act_ready, o_obs_valid}), 256'({1'b1, 1'b0}));
        do_step(2'd2, 7, 1'b0, 32'hbeff0000, 0, 1'b0, ended);
        check("step_cnt_1", 256'(o_step_cnt), 256'(16'd1));
        do_step(2'd0, 3, 1'b0, $urandom, 10, 1'b1, ended);
        ended = 1'b0;
        k = 0;
        while (!ended && k < MAX_STEPS + 5) begin
            do_step(2'($urandom_range(0, 2)), $urandom_range(1, 5), 1'b0, $urandom,
                    $urandom_range(0, 1), 1'b1, ended);
            k++;
        end
        check("trunc_end", 256'({ended, o_obs_trunc, o_obs_done, o_step_cnt, o_ep_cnt}),
              256'({1'b1, 1'b1, 1'b0, 16'(MAX_STEPS), 32'd1}));
        repeat (3) @(negedge i_clk);
        check("idle_hold", 256'({o_obs_valid, o_act_ready, o_step_cnt}), 256'({1'b0, 1'b0, 16'(MAX_STEPS)}));

        // Episode 2: done coincides with the step limit
        start_ep(32'hbf19999a);
        ended = 1'b0;
        k = 0;
        while (!ended && k < MAX_STEPS + 5) begin
            do_step(2'($urandom_range(0, 2)), $urandom_range(1, 4), (m_step + 1 == MAX_STEPS),
                    $urandom, 0, 1'b0, ended);
            k++;
        end
        check("done_priority", 256'({o_obs_done, o_obs_trunc, o_step_cnt, o_ep_cnt}),
              256'({1'b1, 1'b0, 16'(MAX_STEPS), 32'd2}));

        // Episode 3: early done at a random step
        start_ep(32'hbee66666);
        k = $urandom_range(3, 10);
        ended = 1'b0;
        while (!ended && m_step < MAX_STEPS) begin
            do_step(2'($urandom_range(0, 2)), $urandom_range(1, 6), (m_step + 1 == k),
                    $urandom, 0, 1'b0, ended);
        end
        check("early_done", 256'({o_obs_done, o_obs_trunc, o_step_cnt, o_ep_cnt}),
              256'({1'b1, 1'b0, 16'(k), 32'd3}));

        // Reset during WAIT_RES discards the pending result
        start_ep(32'hbf000000);
        i_act_valid = 1'b1; i_act = 2'd1;
        @(negedge i_clk);
        i_act_valid = 1'b0;
        repeat (3) @(negedge i_clk);
        i_rst_n = 1'b0;
        #1;
        check("mid_reset", all_outputs(), 256'(0));
        @(negedge i_clk);
        i_rst_n = 1'b1;
        m_ep = 0;
        i_cmp_valid = 1'b1; i_cmp_pos = 32'h3f000000; i_cmp_done = 1'b1;
        @(negedge i_clk);
        i_cmp_valid = 1'b0; i_cmp_done = 1'b0;
        @(negedge i_clk);
        check("late_result_ignored", all_outputs(), 256'(0));
        start_ep(32'hbf0ccccd);
        do_step(2'd2, 2, 1'b0, $urandom, 0, 1'b0, ended);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/mountaincar_episode_ctrl.md
Name: mountaincar_episode_ctrl

Overview:
- Drives MountainCar_Compute_Single: owns the episode state registers (pos, vel, step count) and issues one compute request per agent action.
- Captures each step result and presents it to the agent as an observation.
- Handles episode start, termination (done), truncation (MAX_STEPS) and episode counting.
- Sits between the agent/policy block and the compute pipeline.

Parameters:
VEL_WL, 32, velocity word width (IEEE-754 single)
POS_WL, 32, position word width (IEEE-754 single)
ACT_WL, 2, action width (0 = left, 1 = none, 2 = right)
RWD_WL, 1, reward width, passed through from compute
MAX_STEPS, 200, step limit per episode before truncation
STEP_WL, 16, step counter width; must hold MAX_STEPS
EP_WL, 32, episode counter width

Ports:
i_clk  in  1  clock
i_rst_n  in  1  asynchronous active-low reset
i_start  in  1  begin episode; sampled only in IDLE
i_init_pos  in  POS_WL  initial position, sampled with i_start (external RNG, range -0.6..-0.4)
i_act_valid  in  1  agent action valid
i_act  in  ACT_WL  agent action
o_act_ready  out  1  controller accepts an action
o_cmp_ena  out  1  single-cycle request pulse to the compute block
o_cmp_pos  out  POS_WL  current position to compute
o_cmp_vel  out  VEL_WL  current velocity to compute
o_cmp_act  out  ACT_WL  latched action to compute
i_cmp_valid  in  1  compute result valid
i_cmp_pos  in  POS_WL  next position
i_cmp_vel  in  VEL_WL  next velocity
i_cmp_rwd  in  RWD_WL  step reward
i_cmp_done  in  1  goal reached
o_obs_valid  out  1  observation valid
i_obs_ready  in  1  agent accepts the observation
o_obs_pos  out  POS_WL  observed position
o_obs_vel  out  VEL_WL  observed velocity
o_obs_rwd  out  RWD_WL  step reward (0 on the initial observation)
o_obs_done  out  1  episode terminated
o_obs_trunc  out  1  episode truncated
o_step_cnt  out  STEP_WL  steps completed in the current episode
o_ep_cnt  out  EP_WL  episodes completed

Behaviour:
- Reset (asynchronous, active-low): state = IDLE. All outputs and registers are 0; o_act_ready = 0.
- States: IDLE, INIT_OBS, WAIT_ACT, ISSUE, WAIT_RES, EMIT_OBS.
- IDLE:
  - On i_start: pos <= i_init_pos, vel <= 32'h00000000, step_cnt <= 0.
  - Go to INIT_OBS.
- INIT_OBS:
  - o_obs_valid = 1 with pos/vel, rwd = 0, done = 0, trunc = 0.
  - On i_obs_ready, go to WAIT_ACT.
- WAIT_ACT:
  - o_act_ready = 1.
  - On i_act_valid & o_act_ready, latch i_act and go to ISSUE.
- ISSUE:
  - o_cmp_ena = 1 for exactly one cycle.
  - o_cmp_pos/vel/act are stable from ISSUE until the result is captured.
  - Go to WAIT_RES.
- WAIT_RES:
  - Wait for the first i_cmp_valid; latency is arbitrary and set by the compute pipeline.
  - On that cycle, register pos, vel, rwd, done; step_cnt += 1.
  - trunc = ~done & (step_cnt+1 == MAX_STEPS).
  - Go to EMIT_OBS.
- i_cmp_valid in any state other than WAIT_RES is ignored and does not change state.
- EMIT_OBS:
  - o_obs_valid = 1; outputs hold stable until i_obs_ready.
  - On handshake with done|trunc: o_ep_cnt += 1 (wraps modulo 2^EP_WL), go to IDLE.
  - On handshake otherwise: go to WAIT_ACT.
- done and step-limit in the same step: done = 1, trunc = 0 (termination has priority).
- o_step_cnt holds its value in IDLE until the next i_start.
- i_start outside IDLE is ignored.
- Reset mid-step: any pending compute result is discarded.
- o_obs_valid and o_act_ready are never high in the same cycle.

Optional Feature:
- Macro MC_AUTO_RESTART_EN.
- Defined: after the done/trunc observation handshake, skip IDLE and start the next episode directly, sampling i_init_pos on that cycle (as if i_start were asserted). Then go to INIT_OBS.
- Not defined: return to IDLE and wait for i_start.

Decomposition:
- Shared package mountaincar_pkg holds:
  - the FSM state enum;
  - float constants MIN_POS = 32'hbf99999a, GOAL_POS = 32'h3f000000, ZERO_VEL = 32'h00000000;
  - the action encodings ACT_LEFT/ACT_NONE/ACT_RIGHT.
- One sub-module is natural: mountaincar_step_counter, holding step_cnt, the truncation compare and ep_cnt.

Test Plan:
- i_start with i_init_pos = 32'hbf000000 (-0.5) -> INIT_OBS shows pos bf000000, vel 0, rwd 0, done 0; o_act_ready rises after the handshake.
- Action 2, compute model latency 7 returning pos 32'hbeff0000 -> exactly one o_cmp_ena pulse; observation equals model output; o_step_cnt = 1.
- Model never asserts done, agent always ready, MAX_STEPS = 200 -> observation 200 has trunc = 1, done = 0; o_ep_cnt = 1; return to IDLE.
- Model asserts done at step 200 -> done = 1, trunc = 0; o_ep_cnt = 1.
- i_obs_ready held low for 10 cycles -> observation outputs stable; spurious i_cmp_valid during EMIT_OBS changes nothing.
- i_rst_n pulsed low during WAIT_RES -> all outputs 0, IDLE; the late i_cmp_valid is ignored.
